// File: rtl/pipelined_addsub_pkg.sv
// Shared helpers for the pipelined adder/subtractor: chunk sizing, the
// legality rule for the WIDTH/STAGES split and the full-adder cell.
package pipelined_addsub_pkg;

    // Bits handled by each pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // The word must split into equal, non-empty chunks.
    function automatic bit split_is_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // One full-adder cell; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream of the pipelined adder/subtractor. The slave side is
// the arithmetic block; the master side feeds operands and drains results.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub_rca_chunk.sv
// Combinational ripple-carry chunk: n full-adder cells in a chain. Besides
// the carry out it exports the carry into its MSB for signed-overflow use.
module pipelined_addsub_rca_chunk
    import pipelined_addsub_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n-1:0] Num1,
    input  logic [n-1:0] Num2,
    input  logic         Cin,
    output logic [n-1:0] Out,
    output logic         Cout,
    output logic         Cmsb
);
    logic carry;

    // Ripple the carry through the cells, LSB first.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path can
        // leave it unassigned (which would infer a latch).
        Out   = '0;
        Cmsb  = Cin;
        carry = Cin;
        // NOTE: blocking assignments on purpose: carry must ripple from cell
        // to cell within a single evaluation of this block.
        for (int i = 0; i < n; i++) begin
            Cmsb             = carry;
            {carry, Out[i]}  = full_add(Num1[i], Num2[i], carry);
        end
        Cout = carry;
    end
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor. Each stage adds one CHUNK of the
// word and forwards its carry; the running word carries finished low chunks
// and still-pending high operand chunks so every beat stays aligned.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic               clk,
    input logic               rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!split_is_legal(WIDTH, STAGES)) begin : g_illegal_split
        $fatal(1, "pipelined_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    // Index 0 is the beat at the input; index k+1 is what stage k registered.
    // acc_s holds A with the low chunks already replaced by result chunks;
    // bp_s holds the not-yet-consumed chunks of B (already inverted for sub).
    logic [WIDTH-1:0] acc_s [STAGES+1];
    logic [WIDTH-1:0] bp_s  [STAGES];
    logic [STAGES:0]  carry_s;
    logic [STAGES:0]  valid_s;
    logic             ovf_q;
    logic             zero_q;
    logic             en;

    // The whole pipeline advances unless a finished result is being held.
    assign en           = !valid_s[STAGES] || bus.out_ready;
    assign bus.in_ready = en;

    assign valid_s[0] = bus.in_valid;
    assign acc_s[0]   = bus.a;
    assign bp_s[0]    = bus.sub ? ~bus.b : bus.b;
    assign carry_s[0] = bus.sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] sum;
        logic             c_out;
        logic [WIDTH-1:0] acc_d;
        logic             valid_q;
        logic [WIDTH-1:0] acc_q;
        logic             carry_q;

        // Drop this stage's sum into its chunk of the running word.
        always_comb begin
            acc_d                   = acc_s[k];
            acc_d[k*CHUNK +: CHUNK] = sum;
        end

        // Stage valid: cleared on reset, frozen while the output stalls.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
            end else if (en) begin
                valid_q <= valid_s[k];
            end
        end

        assign valid_s[k+1] = valid_q;
        assign acc_s[k+1]   = acc_q;
        assign carry_s[k+1] = carry_q;

        if (k == STAGES - 1) begin : g_last
            logic c_msb;

            pipelined_addsub_rca_chunk #(.n(CHUNK)) u_chunk (
                .Num1 (acc_s[k][k*CHUNK +: CHUNK]),
                .Num2 (bp_s[k][k*CHUNK +: CHUNK]),
                .Cin  (carry_s[k]),
                .Out  (sum),
                .Cout (c_out),
                .Cmsb (c_msb)
            );

            // Output register: result plus flags, all cleared on reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    acc_q   <= '0;
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    zero_q  <= 1'b0;
                end else if (en) begin
                    acc_q   <= acc_d;
                    carry_q <= c_out;
                    ovf_q   <= c_msb ^ c_out;
                    zero_q  <= (acc_d == '0);
                end
            end
        end else begin : g_mid
            logic             c_msb_unused;
            logic [WIDTH-1:0] bp_d;
            logic [WIDTH-1:0] bp_q;

            pipelined_addsub_rca_chunk #(.n(CHUNK)) u_chunk (
                .Num1 (acc_s[k][k*CHUNK +: CHUNK]),
                .Num2 (bp_s[k][k*CHUNK +: CHUNK]),
                .Cin  (carry_s[k]),
                .Out  (sum),
                .Cout (c_out),
                .Cmsb (c_msb_unused)
            );

            // The consumed B chunk is zeroed so only pending chunks are stored.
            always_comb begin
                bp_d                   = bp_s[k];
                bp_d[k*CHUNK +: CHUNK] = '0;
            end

            // Intermediate datapath registers.
            // NOTE: no reset here on purpose: the stage valid bit already
            // discards whatever these hold, so resetting wide data is wasted.
            always_ff @(posedge clk) begin
                if (en) begin
                    acc_q   <= acc_d;
                    carry_q <= c_out;
                    bp_q    <= bp_d;
                end
            end

            assign bp_s[k+1] = bp_q;
        end
    end

    assign bus.out_valid = valid_s[STAGES];
    assign bus.result    = acc_s[STAGES];
    assign bus.cout      = carry_s[STAGES];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: four configurations share one stimulus stream,
// each with its own scoreboard; hand-computed vectors target the 32/4 build.
module tb_pipelined_addsub;
    localparam int NCFG = 4;
    localparam int S0   = 4;

    function automatic int cfg_w(input int g);
        case (g)
            0:       return 32;
            1:       return 8;
            2:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_s(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 16;
            default: return 8;
        endcase
    endfunction

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        o;
        logic        z;
        int          stamp;
        bit          lat_ok;
        int          hand;
    } exp_t;

    // Reference: plain wide addition, overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic s);
        logic [63:0] m, bb, r;
        logic [64:0] total;
        exp_t        e;
        m      = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        bb     = (s ? ~b : b) & m;
        total  = {1'b0, a & m} + {1'b0, bb} + 65'(s);
        r      = total[63:0] & m;
        e.res  = r;
        e.c    = total[w];
        e.o    = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
        e.z    = (r == 64'd0);
        e.stamp  = 0;
        e.lat_ok = 1'b0;
        e.hand   = 0;
        return e;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sub = 1'b0;
    logic [63:0] a_drv = '0;
    logic [63:0] b_drv = '0;
    int          hand_kind = 0;
    bit          lat_chk = 1'b1;
    bit          drain_chk = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [NCFG-1:0] ov_all;
    logic [NCFG-1:0] ir_all;
    logic [31:0]     res0;
    logic            c0, o0, z0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W = cfg_w(g);
        localparam int S = cfg_s(g);

        pipelined_addsub_if #(.WIDTH(W)) bus ();

        pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.in_valid  = in_valid;
        assign bus.a         = a_drv[W-1:0];
        assign bus.b         = b_drv[W-1:0];
        assign bus.sub       = sub;
        assign bus.out_ready = out_ready;
        assign ov_all[g]     = bus.out_valid;
        assign ir_all[g]     = bus.in_ready;

        // Scoreboard: sample away from the rising edge, predict the transfers
        // that the next edge will make.
        initial begin : mon
            exp_t        q[$];
            exp_t        e;
            logic        held_v;
            logic [W-1:0] held_r;
            logic [2:0]  held_f;
            string       p;
            held_v = 1'b0;
            held_r = '0;
            held_f = '0;
            p = $sformatf("cfg%0d", g);
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    q.delete();
                    held_v = 1'b0;
                end else begin
                    check({p, "_in_ready"}, 64'(bus.in_ready), 64'(!bus.out_valid || out_ready));
                    if (held_v && bus.out_valid) begin
                        check({p, "_hold_result"}, 64'(bus.result), 64'(held_r));
                        check({p, "_hold_flags"}, 64'({bus.cout, bus.ovf, bus.zero}), 64'(held_f));
                    end
                    held_v = bus.out_valid && !out_ready;
                    held_r = bus.result;
                    held_f = {bus.cout, bus.ovf, bus.zero};
                    if (bus.in_valid && bus.in_ready) begin
                        e = model(W, a_drv, b_drv, sub);
                        e.stamp  = cyc;
                        e.lat_ok = lat_chk;
                        e.hand   = hand_kind;
                        q.push_back(e);
                    end
                    if (bus.out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            check({p, "_extra_beat"}, 64'(bus.out_valid), 64'd0);
                        end else begin
                            e = q.pop_front();
                            check({p, "_result"}, 64'(bus.result), e.res);
                            check({p, "_cout"}, 64'(bus.cout), 64'(e.c));
                            check({p, "_ovf"}, 64'(bus.ovf), 64'(e.o));
                            check({p, "_zero"}, 64'(bus.zero), 64'(e.z));
                            if (e.lat_ok && lat_chk)
                                check({p, "_latency"}, 64'(cyc - e.stamp), 64'(S));
                            if (e.hand == 1) begin
                                check({p, "_wrap_result"}, 64'(bus.result), 64'd0);
                                check({p, "_wrap_flags"}, 64'({bus.cout, bus.ovf, bus.zero}), 64'b101);
                            end else if (e.hand == 2) begin
                                check({p, "_borrow_result"}, 64'(bus.result), 64'({W{1'b1}}));
                                check({p, "_borrow_flags"}, 64'({bus.cout, bus.ovf, bus.zero}), 64'b000);
                            end
                        end
                    end
                    if (drain_chk)
                        check({p, "_pending_after_drain"}, 64'(q.size()), 64'd0);
                end
            end
        end
    end

    assign res0 = g_dut[0].bus.result;
    assign c0   = g_dut[0].bus.cout;
    assign o0   = g_dut[0].bus.ovf;
    assign z0   = g_dut[0].bus.zero;

    // Single beat into the 32-bit/4-stage build, checked at the exact latency.
    task automatic directed32(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic s, input logic [31:0] er, input logic ec,
                              input logic eo, input logic ez);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_drv    = {32'd0, a};
        b_drv    = {32'd0, b};
        sub      = s;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(ir_all[0]), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (S0 - 2) @(posedge clk);
        @(negedge clk);
        check({tag, "_not_early"}, 64'(ov_all[0]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_out_valid"}, 64'(ov_all[0]), 64'd1);
        check({tag, "_result"}, 64'(res0), 64'(er));
        check({tag, "_flags"}, 64'({c0, o0, z0}), 64'({ec, eo, ez}));
    endtask

    task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input logic s,
                             input int hk);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        a_drv     = a;
        b_drv     = b;
        sub       = s;
        hand_kind = hk;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        hand_kind = 0;
    endtask

    task automatic drain_and_check(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
        drain_chk = 1'b1;
        @(posedge clk);
        #1;
        drain_chk = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  sent;
        int  guard;
        bit  took;

        // Reset: in_ready must read 1 throughout, outputs clear afterwards.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(ir_all), 64'(4'b1111));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(ov_all), 64'd0);
        check("rst_result", 64'(res0), 64'd0);
        check("rst_flags", 64'({c0, o0, z0}), 64'd0);

        // Hand-computed vectors on the 32-bit build.
        directed32("carry_chain", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        directed32("signed_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed32("sub_equal",   32'd5,         32'd5,         1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed32("sub_borrow",  32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed32("add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed32("sub_min_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Width-independent boundaries for every build.
        send_beat('1, 64'd1, 1'b0, 1);
        send_beat('0, 64'd1, 1'b1, 2);
        drain_and_check(24);

        // Back-to-back random stream, never stalled.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a_drv    = {$urandom, $urandom};
            b_drv    = {$urandom, $urandom};
            sub      = 1'($urandom_range(1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain_and_check(24);

        // Same stream with random back-pressure.
        lat_chk = 1'b0;
        sent    = 0;
        guard   = 0;
        took    = 1'b0;
        while (sent < 100 && guard < 3000) begin
            @(posedge clk);
            #1;
            if (!in_valid || took) begin
                in_valid = 1'b1;
                a_drv    = {$urandom, $urandom};
                b_drv    = {$urandom, $urandom};
                sub      = 1'($urandom_range(1));
            end
            out_ready = 1'($urandom_range(1));
            @(negedge clk);
            took = in_valid && ir_all[0];
            if (took) sent++;
            guard++;
        end
        check("stall_beats_sent", 64'(sent), 64'd100);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain_and_check(40);
        lat_chk = 1'b1;

        // Reset with the pipeline full: nothing in flight may ever emerge.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a_drv    = {$urandom, $urandom};
            b_drv    = {$urandom, $urandom};
            sub      = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_reset_idle", 64'(ov_all), 64'd0);
        end
        directed32("after_reset", 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
        drain_and_check(24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
